// File: rtl/aurora_rx_parser_if.sv
// rtl/aurora_rx_parser_if.sv - Aurora receive lane, payload FIFO write port and status bundle
interface aurora_rx_parser_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 18,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_data_src_rdy;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_wr_en;
    logic [LEN_W-1:0]  partner_empty_slots;
    logic              partner_empty_slots_valid;
    logic              in_packet;
    logic              hdr_err;
    logic              len_err;
    logic              overflow;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  hdr_err_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output rx_data, rx_data_src_rdy, fifo_full,
        input  fifo_data, fifo_wr_en, partner_empty_slots, partner_empty_slots_valid,
               in_packet, hdr_err, len_err, overflow, pkt_cnt, hdr_err_cnt, drop_cnt
    );

    modport slave (
        input  rx_data, rx_data_src_rdy, fifo_full,
        output fifo_data, fifo_wr_en, partner_empty_slots, partner_empty_slots_valid,
               in_packet, hdr_err, len_err, overflow, pkt_cnt, hdr_err_cnt, drop_cnt
    );
endinterface

// File: rtl/aurora_rx_parser.sv
// rtl/aurora_rx_parser.sv - splits an Aurora word stream into control slot counts and payload FIFO writes
module aurora_rx_parser #(
    parameter int              DATA_W    = 32,
    parameter int              LEN_W     = 18,
    parameter int              HEAD_W    = 4,
    parameter logic [HEAD_W-1:0] CTRL_HEAD = 4'hC,
    parameter logic [HEAD_W-1:0] DATA_HEAD = 4'hD,
    parameter int              MAX_LEN   = 2**LEN_W-1,
    parameter int              CNT_W     = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    aurora_rx_parser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECEIVE, DISCARD} state_t;

    localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W+1)'(MAX_LEN);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [HEAD_W-1:0] head;
    logic [LEN_W-1:0]  len_f;
    logic              last_word;

    assign head      = bus.rx_data[DATA_W-1 -: HEAD_W];
    assign len_f     = bus.rx_data[LEN_W-1:0];
    assign last_word = (remaining == LEN_W'(1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state                         <= IDLE;
            remaining                     <= '0;
            bus.fifo_data                 <= '0;
            bus.fifo_wr_en                <= 1'b0;
            bus.partner_empty_slots       <= '0;
            bus.partner_empty_slots_valid <= 1'b0;
            bus.in_packet                 <= 1'b0;
            bus.hdr_err                   <= 1'b0;
            bus.len_err                   <= 1'b0;
            bus.overflow                  <= 1'b0;
            bus.pkt_cnt                   <= '0;
            bus.hdr_err_cnt               <= '0;
            bus.drop_cnt                  <= '0;
        end else begin
            bus.fifo_wr_en                <= 1'b0;
            bus.partner_empty_slots_valid <= 1'b0;
            bus.hdr_err                   <= 1'b0;
            bus.len_err                   <= 1'b0;
            if (bus.rx_data_src_rdy) begin
                case (state)
                    IDLE: begin
                        if (head == CTRL_HEAD) begin
                            bus.partner_empty_slots       <= len_f;
                            bus.partner_empty_slots_valid <= 1'b1;
                        end else if (head == DATA_HEAD) begin
                            if (len_f == '0) begin
                                bus.pkt_cnt <= sat_inc(bus.pkt_cnt);
                            end else if ({1'b0, len_f} <= MAX_LEN_X) begin
                                remaining     <= len_f;
                                state         <= RECEIVE;
                                bus.in_packet <= 1'b1;
                            end else begin
                                // oversized packets are still walked word by word so the stream stays aligned
                                remaining       <= len_f;
                                state           <= DISCARD;
                                bus.in_packet   <= 1'b1;
                                bus.len_err     <= 1'b1;
                                bus.hdr_err_cnt <= sat_inc(bus.hdr_err_cnt);
                            end
                        end else begin
                            bus.hdr_err     <= 1'b1;
                            bus.hdr_err_cnt <= sat_inc(bus.hdr_err_cnt);
                        end
                    end
                    RECEIVE: begin
                        if (!bus.fifo_full) begin
                            bus.fifo_data  <= bus.rx_data;
                            bus.fifo_wr_en <= 1'b1;
                        end else begin
                            bus.overflow <= 1'b1;
                            bus.drop_cnt <= sat_inc(bus.drop_cnt);
                        end
                        remaining <= remaining - 1'b1;
                        if (last_word) begin
                            state         <= IDLE;
                            bus.in_packet <= 1'b0;
                            bus.pkt_cnt   <= sat_inc(bus.pkt_cnt);
                        end
                    end
                    DISCARD: begin
                        remaining <= remaining - 1'b1;
                        if (last_word) begin
                            state         <= IDLE;
                            bus.in_packet <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        bus.in_packet <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/aurora_rx_parser.md
AURORA_RX_PARSER -- requirements
Module: aurora_rx_parser

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, lane word width.
- LEN_W, 18, length/slot field width, taken from bits [LEN_W-1:0].
- HEAD_W, 4, header code width, taken from bits [DATA_W-1:DATA_W-HEAD_W].
- CTRL_HEAD, 4'hC, control-word code.
- DATA_HEAD, 4'hD, data-header code.
- MAX_LEN, 2**LEN_W-1, largest accepted payload length.
- CNT_W, 16, status counter width.
REQ-002 Ports SHALL be:
- clk_i, in, 1: single clock; all logic is on its rising edge.
- reset_i, in, 1: reset, asynchronous and active-high.
- rx_data, in, DATA_W: Aurora receive word.
- rx_data_src_rdy, in, 1: rx_data valid this cycle.
- fifo_full, in, 1: downstream write FIFO is full.
- fifo_data, out, DATA_W: payload word.
- fifo_wr_en, out, 1: payload write strobe.
- partner_empty_slots, out, LEN_W: slot count from a control word.
- partner_empty_slots_valid, out, 1: one-cycle pulse marking a new slot count.
- in_packet, out, 1: high while in RECEIVE or DISCARD.
- hdr_err, out, 1: one-cycle pulse on an unknown header.
- len_err, out, 1: one-cycle pulse on length > MAX_LEN.
- overflow, out, 1: sticky; set when a payload word is dropped because fifo_full was high.
- pkt_cnt, out, CNT_W: count of completed data packets.
- hdr_err_cnt, out, CNT_W: count of header and length errors.
- drop_cnt, out, CNT_W: count of payload words dropped.

Function
REQ-003 The state machine SHALL have states IDLE, RECEIVE and DISCARD.
REQ-004 The block SHALL act only on cycles with rx_data_src_rdy=1; invalid cycles change no state and no counter.
REQ-005 In IDLE, a valid word with code CTRL_HEAD SHALL register bits [LEN_W-1:0] to partner_empty_slots and pulse partner_empty_slots_valid on the next cycle; the state stays IDLE.
REQ-006 partner_empty_slots SHALL hold its last value between control words; partner_empty_slots_valid SHALL be high for exactly one cycle per control word.
REQ-007 In IDLE, a valid DATA_HEAD word SHALL behave by its length field N:
- N=0: pkt_cnt increments; state stays IDLE.
- 1<=N<=MAX_LEN: remaining<=N; state goes to RECEIVE.
- N>MAX_LEN: len_err pulses; hdr_err_cnt increments; remaining<=N; state goes to DISCARD.
REQ-008 In IDLE, any other header code SHALL pulse hdr_err, increment hdr_err_cnt and leave the state at IDLE.
REQ-009 Header words SHALL never be written to the FIFO.
REQ-010 In RECEIVE, each valid word SHALL be presented on fifo_data with fifo_wr_en=1 exactly one cycle later (latency 1), if fifo_full=0 in the acceptance cycle.
REQ-011 In RECEIVE, a valid word arriving while fifo_full=1 SHALL be dropped: fifo_wr_en stays 0, overflow sets, drop_cnt increments, and remaining still decrements.
REQ-012 In RECEIVE and DISCARD, remaining SHALL decrement by 1 per valid word; the valid word accepted with remaining=1 SHALL return the state to IDLE.
REQ-013 Leaving RECEIVE on the last word SHALL increment pkt_cnt; leaving DISCARD SHALL NOT.
REQ-014 In DISCARD, words SHALL be consumed without any FIFO writes and without drop_cnt changes.
REQ-015 Payload words whose top bits equal CTRL_HEAD or DATA_HEAD SHALL be treated as data; header decoding occurs only in IDLE.
REQ-016 When idle or invalid, fifo_wr_en SHALL be 0 and fifo_data SHALL hold its previous value.
REQ-017 All counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-018 Simultaneous events SHALL be handled as follows:
- An error and a drop in the same cycle cannot occur, since the states are exclusive.
- When the last payload word is dropped, pkt_cnt and drop_cnt SHALL both increment.
REQ-019 in_packet SHALL be a registered decode of the state (RECEIVE or DISCARD).

Reset
REQ-020 While reset_i=1, asynchronously:
- state = IDLE; remaining = 0.
- All outputs, counters, overflow and partner_empty_slots = 0.
REQ-021 A reset asserted mid-packet SHALL abandon the packet without incrementing pkt_cnt; the first valid word after release SHALL be parsed as a header.
REQ-022 overflow SHALL clear only on reset.

Verification
REQ-023 Control word 0xC000_0100 valid for 1 cycle -> next cycle partner_empty_slots=0x100 with valid=1 for one cycle; no FIFO write.
REQ-024 Header 0xD000_0003 then payloads 0xA1, 0xA2, 0xA3 back-to-back -> three fifo_wr_en pulses, each one cycle after its input, data in order; pkt_cnt=1; state returns to IDLE.
REQ-025 Header with N=4 and payloads separated by gaps of rx_data_src_rdy=0, where the 2nd payload is 0xC000_0005 -> it is written as data; partner_empty_slots_valid does not pulse; 4 writes total.
REQ-026 Header N=3 with fifo_full=1 during the 2nd payload -> 2 writes; drop_cnt=1; overflow=1; pkt_cnt=1.
REQ-027 With MAX_LEN=8:
- Header 0xD000_0010 -> len_err pulses; 16 words consumed with no writes; hdr_err_cnt=1.
- Header 0x5000_0000 -> hdr_err pulses.
REQ-028 reset_i asserted after 2 of 5 payloads, then a control word -> outputs zero during reset; control word decoded normally afterwards; pkt_cnt=0.
